// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressed, little-endian data memory with per-byte
// write enables, a valid/ready request port and a registered one-cycle
// response carrying load data and an out-of-range ERROR flag.
//
// Build option: define DMEM_INIT_CLEAR_EN to compile in the INIT state and
// the sequential clear engine, which writes INIT_WORD0 to word 0 and zero
// to every other word after each reset. Without it the block comes out of
// reset directly into IDLE, BUSY is tied low and storage is uninitialised.
module byte_data_memory #(
    parameter int unsigned           DATA_WIDTH  = 16,
    parameter int unsigned           ADDR_WIDTH  = 16,
    parameter int unsigned           DEPTH_BYTES = 128,
    parameter logic [DATA_WIDTH-1:0] INIT_WORD0  = DATA_WIDTH'(16'hAB99)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0]   ADDRESS,
    input  logic [DATA_WIDTH/8-1:0] BYTE_EN,
    input  logic [DATA_WIDTH-1:0]   DATA_IN,
    output logic                    RSP_VALID,
    output logic [DATA_WIDTH-1:0]   DATA_OUT,
    output logic                    ERROR,
    output logic                    BUSY
);

    localparam int unsigned         LANES     = DATA_WIDTH / 8;
    localparam int unsigned         IDX_W     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    // Depth widened to the carry-extended address width so lane sums never wrap.
    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH_BYTES);

    logic [7:0] mem [DEPTH_BYTES];

    // Response / handshake registers
    logic                  ready_q;
    logic                  ready_d;
    logic                  rsp_valid_q;
    logic                  rsp_error_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  accept;

    // Request decode
    logic [LANES-1:0][ADDR_WIDTH:0] lane_addr;
    logic [LANES-1:0][IDX_W-1:0]    lane_idx;
    logic [LANES-1:0]               lane_oor;
    logic                           req_error;
    logic [DATA_WIDTH-1:0]          load_data;

    // Clear engine view shared with the write port
    logic             clr_active;
    logic [IDX_W-1:0] clr_base;

    // Byte write port (one write per lane per cycle)
    logic [LANES-1:0]            wr_en;
    logic [LANES-1:0][IDX_W-1:0] wr_idx;
    logic [LANES-1:0][7:0]       wr_byte;

    // READY is a register, so it has no combinational path from REQ_VALID.
    assign accept = REQ_VALID && ready_q;

`ifdef DMEM_INIT_CLEAR_EN
    localparam int unsigned WORDS = DEPTH_BYTES / LANES;
    localparam int unsigned CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [0:0]  ST_INIT = 1'b0;
    localparam logic [0:0]  ST_IDLE = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] clr_cnt_q;
    logic [CNT_W-1:0] clr_cnt_d;

    // Next state: INIT walks the word counter once, then IDLE forever.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_INIT) begin
            clr_cnt_d = clr_cnt_q + CNT_W'(1);
            if (clr_cnt_q == CNT_W'(WORDS - 1)) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        end
    end

    // FSM and clear counter; a reset mid-clear restarts from word 0.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (!RST) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clr_active = (state_q == ST_INIT);
    assign clr_base   = IDX_W'(int'(clr_cnt_q) * int'(LANES));
    assign ready_d    = (state_d == ST_IDLE);
    assign BUSY       = (state_q == ST_INIT);
`else
    assign clr_active = 1'b0;
    assign clr_base   = '0;
    assign ready_d    = 1'b1;
    assign BUSY       = 1'b0;
`endif

    // Per-lane address, range check and load-data gather.
    always_comb begin
        lane_addr = '0;
        lane_idx  = '0;
        lane_oor  = '0;
        load_data = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_addr[k] = {1'b0, ADDRESS} + (ADDR_WIDTH+1)'(k);
            lane_idx[k]  = lane_addr[k][IDX_W-1:0];
            lane_oor[k]  = BYTE_EN[k] && (lane_addr[k] >= DEPTH_EXT);
        end
        req_error = |lane_oor;
        for (int k = 0; k < LANES; k++) begin
            if (BYTE_EN[k] && !lane_oor[k]) begin
                load_data[8*k +: 8] = mem[lane_idx[k]];
            end
        end
    end

    // Write-port mux: clear engine while INIT, otherwise accepted in-range stores.
    always_comb begin
        wr_en   = '0;
        wr_idx  = '0;
        wr_byte = '0;
        if (clr_active) begin
            for (int k = 0; k < LANES; k++) begin
                wr_en[k]   = 1'b1;
                wr_idx[k]  = clr_base + IDX_W'(k);
                wr_byte[k] = (clr_base == '0) ? INIT_WORD0[8*k +: 8] : 8'h00;
            end
        end else if (accept && REQ_WRITE && !req_error) begin
            for (int k = 0; k < LANES; k++) begin
                wr_en[k]   = BYTE_EN[k];
                wr_idx[k]  = lane_idx[k];
                wr_byte[k] = DATA_IN[8*k +: 8];
            end
        end
    end

    // Byte storage.
    always_ff @(posedge CLK) begin
        // NOTE: storage has no reset; contents survive reset and only the clear engine initialises them.
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                mem[wr_idx[k]] <= wr_byte[k];
            end
        end
    end

    // Handshake and response registers; DATA_OUT/ERROR hold between responses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ready_q     <= ready_d;
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_error_q <= req_error;
                rsp_data_q  <= (REQ_WRITE || req_error) ? '0 : load_data;
            end
        end
    end

    assign REQ_READY = ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign DATA_OUT  = rsp_data_q;
    assign ERROR     = rsp_error_q;

endmodule

// File: tb/tb_byte_data_memory.sv
// Self-checking bench for byte_data_memory (default parameters).
// Works in both builds; clear-engine checks are compiled in with
// DMEM_INIT_CLEAR_EN. A byte-array reference model predicts every response.
module tb_byte_data_memory;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 128;

`ifdef DMEM_INIT_CLEAR_EN
    localparam logic EXP_BUSY        = 1'b1;
    localparam int   EXP_READY_EDGES = DEPTH / 2;
`else
    localparam logic EXP_BUSY        = 1'b0;
    localparam int   EXP_READY_EDGES = 1;
`endif

    logic          CLK       = 1'b0;
    logic          RST       = 1'b0;
    logic          REQ_VALID = 1'b0;
    logic          REQ_WRITE = 1'b0;
    logic [AW-1:0] ADDRESS   = '0;
    logic [1:0]    BYTE_EN   = '0;
    logic [DW-1:0] DATA_IN   = '0;
    logic          REQ_READY;
    logic          RSP_VALID;
    logic [DW-1:0] DATA_OUT;
    logic          ERROR;
    logic          BUSY;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_mem [DEPTH];

    always #5 CLK = ~CLK;

    byte_data_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH_BYTES(DEPTH),
        .INIT_WORD0 (16'hAB99)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_WRITE(REQ_WRITE),
        .ADDRESS  (ADDRESS),
        .BYTE_EN  (BYTE_EN),
        .DATA_IN  (DATA_IN),
        .RSP_VALID(RSP_VALID),
        .DATA_OUT (DATA_OUT),
        .ERROR    (ERROR),
        .BUSY     (BUSY)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    // Reference: apply one request to the byte array and predict the response.
    function automatic void model_access(input logic wr, input int addr, input logic [1:0] be,
                                         input logic [DW-1:0] din,
                                         output logic e_err, output logic [DW-1:0] e_data);
        e_err  = 1'b0;
        e_data = '0;
        for (int k = 0; k < 2; k++)
            if (be[k] && (addr + k >= DEPTH)) e_err = 1'b1;
        if (!e_err) begin
            for (int k = 0; k < 2; k++) begin
                if (be[k]) begin
                    if (wr) model_mem[addr + k] = din[8*k +: 8];
                    else    e_data[8*k +: 8]    = model_mem[addr + k];
                end
            end
        end
    endfunction

`ifdef DMEM_INIT_CLEAR_EN
    function automatic void set_clear_image();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_mem[0] = 8'h99;
        model_mem[1] = 8'hAB;
    endfunction
`endif

    // Present one request for exactly one edge; returns #1 after that edge.
    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [1:0] be,
                        input logic [DW-1:0] din);
        @(negedge CLK);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        ADDRESS   = addr;
        BYTE_EN   = be;
        DATA_IN   = din;
        @(posedge CLK);
        #1;
    endtask

    task automatic xact(input logic wr, input logic [AW-1:0] addr, input logic [1:0] be,
                        input logic [DW-1:0] din,
                        output logic e_err, output logic [DW-1:0] e_data);
        model_access(wr, int'(addr), be, din, e_err, e_data);
        send(wr, addr, be, din);
    endtask

    task automatic idle();
        @(negedge CLK);
        REQ_VALID = 1'b0;
        REQ_WRITE = 1'b0;
        BYTE_EN   = '0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({REQ_READY, RSP_VALID, ERROR, BUSY, DATA_OUT} !== {1'b0, 1'b0, 1'b0, EXP_BUSY, 16'h0000}) begin
            bad++;
            $display("FAIL reset_values: ready/valid/err/busy/data=%b%b%b%b %h want 000%b 0000",
                     REQ_READY, RSP_VALID, ERROR, BUSY, DATA_OUT, EXP_BUSY);
        end
    endtask

    // Release reset and count edges until READY rises (bounded).
    task automatic test_release();
        int n = 0;
        int busy_bad = 0;
        @(negedge CLK);
        RST = 1'b1;
        while (n < 200) begin
            @(posedge CLK);
            #1;
            n++;
            if (REQ_READY === 1'b1) break;
            if (BUSY !== EXP_BUSY) busy_bad++;
        end
        total++;
        if (n != EXP_READY_EDGES || REQ_READY !== 1'b1) begin
            bad++;
            $display("FAIL ready_rise: ready=%b after %0d edges want 1 after %0d", REQ_READY, n, EXP_READY_EDGES);
        end
        total++;
        if (busy_bad != 0 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL busy_during_init: busy_bad=%0d busy_now=%b want 0 and 0", busy_bad, BUSY);
        end
    endtask

`ifdef DMEM_INIT_CLEAR_EN
    task automatic test_clear_contents();
        logic ee;
        logic [DW-1:0] ed;
        set_clear_image();
        xact(1'b0, 16'd0, 2'b11, 16'h0, ee, ed);
        total++;
        if (RSP_VALID !== 1'b1 || DATA_OUT !== 16'hAB99) begin
            bad++;
            $display("FAIL clear_word0: valid=%b data=%h want 1 ab99", RSP_VALID, DATA_OUT);
        end
        xact(1'b0, 16'd2, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h0000) begin
            bad++;
            $display("FAIL clear_word1: data=%h want 0000", DATA_OUT);
        end
        idle();
    endtask
`endif

    // Zero every word through the store path so the model is fully known.
    task automatic test_fill();
        logic ee;
        logic [DW-1:0] ed;
        for (int w = 0; w < DEPTH / 2; w++) begin
            xact(1'b1, AW'(2 * w), 2'b11, 16'h0000, ee, ed);
            total++;
            if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, 1'b0, 16'h0000}) begin
                bad++;
                $display("FAIL fill_store w=%0d: valid=%b err=%b data=%h want 1 0 0000", w, RSP_VALID, ERROR, DATA_OUT);
            end
        end
        idle();
    endtask

    task automatic test_unaligned();
        logic ee;
        logic [DW-1:0] ed;
        xact(1'b1, 16'd5, 2'b11, 16'h1234, ee, ed);
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL unaligned_store: valid=%b err=%b data=%h want 1 0 0000", RSP_VALID, ERROR, DATA_OUT);
        end
        xact(1'b0, 16'd4, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h3400) begin bad++; $display("FAIL unaligned_load4: data=%h want 3400", DATA_OUT); end
        xact(1'b0, 16'd6, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h0012) begin bad++; $display("FAIL unaligned_load6: data=%h want 0012", DATA_OUT); end
        xact(1'b0, 16'd5, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h1234) begin bad++; $display("FAIL unaligned_load5: data=%h want 1234", DATA_OUT); end
        idle();
    endtask

    task automatic test_byte_enable();
        logic ee;
        logic [DW-1:0] ed;
        xact(1'b1, 16'd8, 2'b01, 16'hBEEF, ee, ed);
        xact(1'b0, 16'd8, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h00EF) begin bad++; $display("FAIL be_low_store: data=%h want 00ef", DATA_OUT); end
        xact(1'b0, 16'd8, 2'b10, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h0000) begin bad++; $display("FAIL be_high_load: data=%h want 0000", DATA_OUT); end
        xact(1'b1, 16'd8, 2'b10, 16'h1122, ee, ed);
        xact(1'b0, 16'd8, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h11EF) begin bad++; $display("FAIL be_high_store: data=%h want 11ef", DATA_OUT); end
        idle();
    endtask

    task automatic test_out_of_range();
        logic ee;
        logic [DW-1:0] ed;
        xact(1'b1, 16'd127, 2'b11, 16'h5A5A, ee, ed);
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL oor_store: valid=%b err=%b data=%h want 1 1 0000", RSP_VALID, ERROR, DATA_OUT);
        end
        xact(1'b0, 16'd127, 2'b01, 16'h0, ee, ed);
        total++;
        if ({ERROR, DATA_OUT} !== {1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL oor_no_write: err=%b data=%h want 0 0000", ERROR, DATA_OUT);
        end
        xact(1'b1, 16'd127, 2'b01, 16'h0077, ee, ed);
        total++;
        if (ERROR !== 1'b0) begin bad++; $display("FAIL last_byte_store: err=%b want 0", ERROR); end
        xact(1'b0, 16'd127, 2'b01, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h0077) begin bad++; $display("FAIL last_byte_load: data=%h want 0077", DATA_OUT); end
        xact(1'b0, 16'd127, 2'b10, 16'h0, ee, ed);
        total++;
        if ({ERROR, DATA_OUT} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL oor_load_lane1: err=%b data=%h want 1 0000", ERROR, DATA_OUT);
        end
        xact(1'b0, 16'hFFFF, 2'b11, 16'h0, ee, ed);
        total++;
        if ({RSP_VALID, ERROR} !== 2'b11) begin
            bad++;
            $display("FAIL oor_top_addr: valid=%b err=%b want 1 1", RSP_VALID, ERROR);
        end
        xact(1'b0, 16'hFFFF, 2'b00, 16'h0, ee, ed);
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL no_lanes: valid=%b err=%b data=%h want 1 0 0000", RSP_VALID, ERROR, DATA_OUT);
        end
        xact(1'b0, 16'd126, 2'b11, 16'h0, ee, ed);
        total++;
        if ({ERROR, DATA_OUT} !== {1'b0, 16'h7700}) begin
            bad++;
            $display("FAIL top_word_load: err=%b data=%h want 0 7700", ERROR, DATA_OUT);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic ee;
        logic [DW-1:0] ed;
        xact(1'b1, 16'd10, 2'b11, 16'hCAFE, ee, ed);
        total++;
        if (RSP_VALID !== 1'b1) begin bad++; $display("FAIL b2b_first: valid=%b want 1", RSP_VALID); end
        xact(1'b0, 16'd10, 2'b11, 16'h0, ee, ed);
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, 1'b0, 16'hCAFE}) begin
            bad++;
            $display("FAIL b2b_second: valid=%b err=%b data=%h want 1 0 cafe", RSP_VALID, ERROR, DATA_OUT);
        end
        idle();
        @(posedge CLK);
        #1;
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b0, 1'b0, 16'hCAFE}) begin
            bad++;
            $display("FAIL hold_data: valid=%b err=%b data=%h want 0 0 cafe", RSP_VALID, ERROR, DATA_OUT);
        end
        xact(1'b0, 16'd200, 2'b11, 16'h0, ee, ed);
        idle();
        @(posedge CLK);
        #1;
        total++;
        if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL hold_error: valid=%b err=%b data=%h want 0 1 0000", RSP_VALID, ERROR, DATA_OUT);
        end
    endtask

    task automatic test_random();
        logic          ee;
        logic [DW-1:0] ed;
        logic          last_e = 1'b0;
        logic [DW-1:0] last_d = '0;
        logic          wr;
        logic [AW-1:0] a;
        logic [1:0]    be;
        logic [DW-1:0] din;
        for (int i = 0; i < 400; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                idle();
                @(posedge CLK);
                #1;
                total++;
                if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b0, last_e, last_d}) begin
                    bad++;
                    $display("FAIL rand_gap i=%0d: valid=%b err=%b data=%h want 0 %b %h",
                             i, RSP_VALID, ERROR, DATA_OUT, last_e, last_d);
                end
            end
            wr  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 15) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH + 2));
            be  = 2'($urandom);
            din = DW'($urandom);
            xact(wr, a, be, din, ee, ed);
            total++;
            if ({RSP_VALID, ERROR, DATA_OUT} !== {1'b1, ee, ed}) begin
                bad++;
                $display("FAIL rand i=%0d wr=%b addr=%0d be=%b: valid=%b err=%b data=%h want 1 %b %h",
                         i, wr, a, be, RSP_VALID, ERROR, DATA_OUT, ee, ed);
            end
            last_e = ee;
            last_d = ed;
        end
        idle();
    endtask

    task automatic test_reset_mid_op();
        logic ee;
        logic [DW-1:0] ed;
        xact(1'b1, 16'd10, 2'b11, 16'hCAFE, ee, ed);
        xact(1'b0, 16'd10, 2'b11, 16'h0, ee, ed);
        #2;
        RST       = 1'b0;
        REQ_VALID = 1'b0;
        #1;
        total++;
        if ({REQ_READY, RSP_VALID, ERROR, BUSY, DATA_OUT} !== {1'b0, 1'b0, 1'b0, EXP_BUSY, 16'h0000}) begin
            bad++;
            $display("FAIL reset_mid_op: ready/valid/err/busy/data=%b%b%b%b %h want 000%b 0000",
                     REQ_READY, RSP_VALID, ERROR, BUSY, DATA_OUT, EXP_BUSY);
        end
`ifdef DMEM_INIT_CLEAR_EN
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        repeat (20) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        total++;
        if ({REQ_READY, RSP_VALID, BUSY} !== 3'b001) begin
            bad++;
            $display("FAIL reset_mid_clear: ready=%b valid=%b busy=%b want 0 0 1", REQ_READY, RSP_VALID, BUSY);
        end
        test_release();
        set_clear_image();
        xact(1'b0, 16'd10, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'h0000) begin bad++; $display("FAIL reclear_word5: data=%h want 0000", DATA_OUT); end
        xact(1'b0, 16'd0, 2'b11, 16'h0, ee, ed);
        total++;
        if (DATA_OUT !== 16'hAB99) begin bad++; $display("FAIL reclear_word0: data=%h want ab99", DATA_OUT); end
`else
        test_release();
        xact(1'b0, 16'd10, 2'b11, 16'h0, ee, ed);
        total++;
        if ({RSP_VALID, DATA_OUT} !== {1'b1, 16'hCAFE}) begin
            bad++;
            $display("FAIL mem_survives_reset: valid=%b data=%h want 1 cafe", RSP_VALID, DATA_OUT);
        end
`endif
        idle();
    endtask

    initial begin
        test_reset();
        test_release();
`ifdef DMEM_INIT_CLEAR_EN
        test_clear_contents();
`endif
        test_fill();
        test_unaligned();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
